// File: rtl/sign_sll.sv
// Registered sign-preserving left shifter: the sign bit is kept, the magnitude
// bits are shifted left by a fixed SHAMT and zero-filled; one cycle of latency.
module sign_sll #(
  parameter int WIDTH = 4,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  logic [WIDTH-2:0] low_shifted;
  logic [WIDTH-1:0] n;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("sign_sll: WIDTH must be 2 or more");
    end
    if (SHAMT < 0) begin : g_bad_shamt
      $error("sign_sll: SHAMT must be 0 or more");
    end
  endgenerate

  // Constant shift of the magnitude field only; SHAMT >= WIDTH-1 leaves it all zero.
  assign low_shifted = a[WIDTH-2:0] << SHAMT;
  assign n           = {a[WIDTH-1], low_shifted};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b <= '0;
    end else begin
      b <= n;
    end
  end

endmodule

// File: tb/tb_sign_sll.sv
// Directed self-checking bench for sign_sll (WIDTH=4/SHAMT=2 plus WIDTH=8
// instances with SHAMT=0 and SHAMT=7).
module tb_sign_sll;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] a8;
  logic [7:0] b8_s0;
  logic [7:0] b8_s7;

  int checks;
  int errors;

  sign_sll #(.WIDTH(4), .SHAMT(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b)
  );

  sign_sll #(.WIDTH(8), .SHAMT(0)) dut_s0 (
    .clk(clk), .rst(rst), .a(a8), .b(b8_s0)
  );

  sign_sll #(.WIDTH(8), .SHAMT(7)) dut_s7 (
    .clk(clk), .rst(rst), .a(a8), .b(b8_s7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic test_reset();
    a  = 4'b1111;
    a8 = 8'h00;
    rst = 1'b1;
    #1;
    checks++;
    if (b !== 4'b0000) begin
      errors++;
      $display("FAIL reset_immediate: got %b required %b", b, 4'b0000);
    end
    $display("reset asserted: b=%b", b);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (b !== 4'b0000) begin
        errors++;
        $display("FAIL reset_held_%0d: got %b required %b", i, b, 4'b0000);
      end
      $display("reset held edge %0d: b=%b", i, b);
    end
  endtask

  task automatic test_negative();
    @(negedge clk);
    rst = 1'b0;
    a   = 4'b1100;
    #1;
    checks++;
    if (b !== 4'b0000) begin
      errors++;
      $display("FAIL neg_before_edge: got %b required %b", b, 4'b0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b !== 4'b1000) begin
      errors++;
      $display("FAIL neg_result: got %b required %b", b, 4'b1000);
    end
    $display("a=1100 -> b=%b", b);
  endtask

  // Each operand is applied at a negedge; b must still hold the previous
  // result until the following rising edge, then show the new one.
  task automatic run_vectors(input string name, input logic [3:0] ins[],
                             input logic [3:0] exps[], input logic [3:0] prev_in);
    logic [3:0] prev;
    prev = prev_in;
    for (int i = 0; i < ins.size(); i++) begin
      @(negedge clk);
      a = ins[i];
      #1;
      checks++;
      if (b !== prev) begin
        errors++;
        $display("FAIL %s_hold_%0d: got %b required %b", name, i, b, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (b !== exps[i]) begin
        errors++;
        $display("FAIL %s_%0d: got %b required %b", name, i, b, exps[i]);
      end
      $display("%s a=%b -> b=%b", name, ins[i], b);
      prev = exps[i];
    end
  endtask

  task automatic test_positive();
    logic [3:0] ins[]  = '{4'b0011, 4'b0111, 4'b0000};
    logic [3:0] exps[] = '{4'b0100, 4'b0100, 4'b0000};
    run_vectors("pos", ins, exps, 4'b1000);
  endtask

  task automatic test_back_to_back_overflow();
    logic [3:0] ins[]  = '{4'b1001, 4'b1111};
    logic [3:0] exps[] = '{4'b1100, 4'b1100};
    run_vectors("ovf", ins, exps, 4'b0000);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", b, 4'b0000);
    end
    $display("mid-stream reset: b=%b", b);
    @(negedge clk);
    rst = 1'b0;
    a   = 4'b0101;
    #1;
    checks++;
    if (b !== 4'b0000) begin
      errors++;
      $display("FAIL async_release_hold: got %b required %b", b, 4'b0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b !== 4'b0100) begin
      errors++;
      $display("FAIL async_release_result: got %b required %b", b, 4'b0100);
    end
    $display("a=0101 -> b=%b", b);
  endtask

  task automatic test_params();
    logic [7:0] ins[]    = '{8'hA5, 8'h7F};
    logic [7:0] exp_s0[] = '{8'hA5, 8'h7F};
    logic [7:0] exp_s7[] = '{8'h80, 8'h00};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a8 = ins[i];
      @(posedge clk);
      #1;
      checks++;
      if (b8_s0 !== exp_s0[i]) begin
        errors++;
        $display("FAIL shamt0_%0d: got %h required %h", i, b8_s0, exp_s0[i]);
      end
      checks++;
      if (b8_s7 !== exp_s7[i]) begin
        errors++;
        $display("FAIL shamt7_%0d: got %h required %h", i, b8_s7, exp_s7[i]);
      end
      $display("w8 a=%h -> shamt0 b=%h shamt7 b=%h", ins[i], b8_s0, b8_s7);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a   = 4'b0000;
    a8  = 8'h00;
    test_reset();
    test_negative();
    test_positive();
    test_back_to_back_overflow();
    test_async_reset();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
